// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcode constants, FSM states and shared constants for the mdu
package mdu_pkg;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  // Iteration count of the 32-bit (W) operations
  localparam int unsigned W_OP_CNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_w(input logic [3:0] op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - one restoring-division step on unsigned magnitudes
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift the next dividend bit into the partial remainder and subtract if it fits;
  // the partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit; divider present only when MDU_DIV_EN is defined
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MDUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [MDUOP_W-1:0] mduop_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    result_o,
  output logic               illegal_o,
  output logic               busy_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_W    = CW'(W_OP_CNT);

`ifdef MDU_DIV_EN
  localparam bit DIV_PRESENT = 1'b1;
`else
  localparam bit DIV_PRESENT = 1'b0;
`endif

  state_e state_q, state_d;
  logic   accept;

  logic [3:0]      op;
  logic            op_ext_nz;
  logic            known, is_w, is_mul, is_quo, is_rem, div_op;
  logic            sx1, sx2, s1, s2;
  logic            illegal_d, div_zero, div_ovf, fast_d;
  logic [XLEN-1:0] w1, w2, m1, m2, fast_raw, fast_res;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, mcand_q;
  logic            w_q, mul_q, sel_hi_q, neg_q, fast_q, ill_q;
  logic            valid_q, illegal_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mulh_res, fin;

  assign op = mduop_i[3:0];

  generate
    if (MDUOP_W > 4) begin : g_op_ext
      assign op_ext_nz = |mduop_i[MDUOP_W-1:4];
    end else begin : g_op_noext
      assign op_ext_nz = 1'b0;
    end
  endgenerate

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q != S_IDLE);
  assign accept   = valid_i && ready_o;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign illegal_o = illegal_q;

  // Decode the presented request: operand narrowing, magnitudes and fast-path result
  always_comb begin
    known  = (op <= OP_REMUW) && !op_ext_nz;
    is_w   = op_is_w(op);
    is_mul = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    is_quo = op inside {OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW};
    is_rem = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    sx1    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    sx2    = op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    div_op = is_quo || is_rem;
    illegal_d = !known || (is_w && (XLEN == 32)) || (div_op && !DIV_PRESENT);

    if (is_w) begin
      w1 = sx1 ? XLEN'(signed'(op1_i[31:0])) : XLEN'(op1_i[31:0]);
      w2 = sx2 ? XLEN'(signed'(op2_i[31:0])) : XLEN'(op2_i[31:0]);
    end else begin
      w1 = op1_i;
      w2 = op2_i;
    end
    s1 = sx1 && w1[XLEN-1];
    s2 = sx2 && w2[XLEN-1];
    m1 = s1 ? -w1 : w1;
    m2 = s2 ? -w2 : w2;

    div_zero = div_op && (w2 == '0);
    if (is_w) begin
      div_ovf = sx2 && div_op && (w1[31:0] == 32'h8000_0000) && (w2[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_ovf = sx2 && div_op && (w1 == {1'b1, {(XLEN-1){1'b0}}}) && (&w2);
    end
    fast_d = illegal_d || div_zero || div_ovf;

    fast_raw = '0;
    if (illegal_d) begin
      fast_raw = '0;
    end else if (div_zero) begin
      fast_raw = is_rem ? w1 : '1;
    end else if (div_ovf) begin
      fast_raw = is_rem ? '0 : w1;
    end
    fast_res = is_w ? XLEN'(signed'(fast_raw[31:0])) : fast_raw;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush wins over everything, including a same-cycle accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast_d ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE: if (valid_q && ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] div_rem, div_quo, dres, dres_fix;

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .rem      (hi_q),
    .quo      (lo_q),
    .divisor  (mcand_q),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  assign dres     = sel_hi_q ? hi_q : lo_q;
  assign dres_fix = neg_q ? -dres : dres;
`endif

  // High half of the signed product: negating {hi,lo} carries into hi only when lo is zero
  assign mulh_res = neg_q ? (~hi_q + XLEN'(lo_q == '0)) : hi_q;

  // Final result selection, consumed on the first DONE cycle
  always_comb begin
    fin = '0;
    if (fast_q) begin
      fin = hi_q;
    end else if (mul_q) begin
      if (w_q) begin
        fin = XLEN'(signed'(lo_q[XLEN-1 -: 32]));
      end else begin
        fin = sel_hi_q ? mulh_res : lo_q;
      end
    end
`ifdef MDU_DIV_EN
    else begin
      fin = w_q ? XLEN'(signed'(dres_fix[31:0])) : dres_fix;
    end
`endif
  end

  // Datapath: capture on accept, one shift-add or restoring step per ITER cycle, publish in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      w_q       <= 1'b0;
      mul_q     <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_q     <= 1'b0;
      fast_q    <= 1'b0;
      ill_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            w_q      <= is_w;
            mul_q    <= is_mul;
            sel_hi_q <= is_mul ? (op != OP_MUL && op != OP_MULW) : is_rem;
            fast_q   <= fast_d;
            ill_q    <= illegal_d;
            if (fast_d) begin
              hi_q    <= fast_res;
              lo_q    <= '0;
              mcand_q <= '0;
              neg_q   <= 1'b0;
              cnt_q   <= '0;
            end else if (is_mul) begin
              hi_q    <= '0;
              lo_q    <= m2;
              mcand_q <= m1;
              neg_q   <= s1 ^ s2;
              cnt_q   <= is_w ? CNT_W : CNT_FULL;
            end else begin
              hi_q    <= '0;
              lo_q    <= is_w ? (m1 << (XLEN - 32)) : m1;
              mcand_q <= m2;
              neg_q   <= is_rem ? s1 : (s1 ^ s2);
              cnt_q   <= is_w ? CNT_W : CNT_FULL;
            end
          end
        end
        S_ITER: begin
          cnt_q <= cnt_q - CW'(1);
          if (mul_q) begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
`ifdef MDU_DIV_EN
          else begin
            hi_q <= div_rem;
            lo_q <= div_quo;
          end
`endif
        end
        S_DONE: begin
          if (!valid_q) begin
            valid_q   <= 1'b1;
            result_q  <= fin;
            illegal_q <= ill_q;
          end else if (ready_i) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (flush_i) valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for mdu; expectations follow MDU_DIV_EN
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [3:0]  mduop_i = '0;
  logic [63:0] op1_i = '0;
  logic [63:0] op2_i = '0;
  logic        ready_o, valid_o, illegal_o, busy_o;
  logic [63:0] result_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic        ill;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  mdu #(.XLEN(64), .MDUOP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .mduop_i   (mduop_i),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .illegal_o (illegal_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: on each new result pop the oldest expectation and compare
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (valid_o && !prev_v) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result 0x%h with nothing outstanding", result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"}, result_o, e.res);
        chk1({e.name, "_ill"}, illegal_o, e.ill);
        chk({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
    prev_v = valid_o;
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input logic ill,
                       input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: ready_o stayed low", name);
      return;
    end
    mduop_i = op;
    op1_i   = a;
    op2_i   = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    e.res  = res;
    e.ill  = ill;
    e.lat  = lat;
    e.acc  = cyc;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic dvec(input string name, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] res, input int lat);
`ifdef MDU_DIV_EN
    issue(name, op, a, b, res, 1'b0, lat);
`else
    issue(name, op, a, b, 64'd0, 1'b1, 1);
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy_o) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout: %0d results outstanding", name, sb.size());
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk1("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 64'd0);
    chk1("rst_illegal", illegal_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_ready", ready_o, 1'b1);
    rst = 1'b1;

    issue("mul_7x6", OP_MUL, 64'd7, 64'd6, 64'h2A, 1'b0, 65);
    issue("mulhu_ones", OP_MULHU, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65);
    issue("mulh_m2x3", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ALL1, 1'b0, 65);
    issue("mulhsu_min", OP_MULHSU, MIN, ALL1, MIN, 1'b0, 65);
    issue("mul_wide", OP_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 1'b0, 65);
    issue("mulw_2p32", OP_MULW, 64'h10000, 64'h10000, 64'd0, 1'b0, 33);
    issue("mulw_sext", OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33);
    issue("undef_13", 4'd13, 64'd1, 64'd2, 64'd0, 1'b1, 1);
    issue("undef_15", 4'd15, 64'd9, 64'd9, 64'd0, 1'b1, 1);

    dvec("div_m20_3", OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    dvec("rem_m20_3", OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    dvec("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    dvec("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    dvec("divu_9_3", OP_DIVU, 64'd9, 64'd3, 64'd3, 65);
    dvec("div_5_0", OP_DIV, 64'd5, 64'd0, ALL1, 1);
    dvec("rem_5_0", OP_REM, 64'd5, 64'd0, 64'd5, 1);
    dvec("div_ovf", OP_DIV, MIN, ALL1, MIN, 1);
    dvec("rem_ovf", OP_REM, MIN, ALL1, 64'd0, 1);
    dvec("divw_m8_2", OP_DIVW, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33);
    dvec("remuw_10", OP_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 33);
    dvec("divuw_hi_ign", OP_DIVUW, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    dvec("divuw_0", OP_DIVUW, 64'd7, 64'h1_0000_0000, ALL1, 1);
    dvec("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
    drain("vectors");

    // Backpressure: result must hold while the consumer stalls
    ready_i = 1'b0;
    issue("mul_bp", OP_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 65);
    n = 0;
    while (!valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("bp_valid_seen", valid_o, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_result", result_o, 64'd15);
      chk1("bp_valid", valid_o, 1'b1);
      chk1("bp_ready", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    drain("bp");

    // Flush in the middle of an iteration
    @(negedge clk);
    mduop_i = OP_MUL; op1_i = 64'd7; op2_i = 64'd6; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk1("flush_busy_before", busy_o, 1'b1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk1("flush_busy", busy_o, 1'b0);
    chk1("flush_ready", ready_o, 1'b1);
    chk1("flush_valid", valid_o, 1'b0);
    quiet("flush_no_valid", 80);

    // Flush coinciding with an accept drops the request
    @(negedge clk);
    mduop_i = OP_MUL; op1_i = 64'd2; op2_i = 64'd2; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk1("flush_acc_busy", busy_o, 1'b0);
    quiet("flush_acc_no_valid", 80);

    // Reset in the middle of an operation
    @(negedge clk);
    mduop_i = OP_MUL; op1_i = 64'd11; op2_i = 64'd11; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_valid", valid_o, 1'b0);
    chk("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet("midrst_no_valid", 80);

    issue("post_rst_mul", OP_MUL, 64'h10, 64'h10, 64'h100, 1'b0, 65);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
